pipe_event_counter: RTL

//  Counts in-CPU pipeline events so that stall/flush/retire statistics come from RTL instead of bench probes.

---
 rtl/pipe_event_counter_if.sv | 25 ++
 rtl/pipe_event_counter.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipe_event_counter_if.sv
// Counter read-back port: a request is sampled at a clock edge and answered one cycle later.
// Handshake: rd_req_i is a single-cycle pulse sampled at edge N; rd_ack_o is high for exactly the
// cycle after edge N and rd_data_o is valid only while rd_ack_o=1. There is no stall path.
interface pipe_event_counter_if #(
  parameter int CNT_W = 32
);
  logic             rd_req_i;
  logic [2:0]       rd_sel_i;
  logic [CNT_W-1:0] rd_data_o;
  logic             rd_ack_o;

  modport master (
    output rd_req_i,
    output rd_sel_i,
    input  rd_data_o,
    input  rd_ack_o
  );

  modport slave (
    input  rd_req_i,
    input  rd_sel_i,
    output rd_data_o,
    output rd_ack_o
  );
endinterface

// File: rtl/pipe_event_counter.sv
// Pipeline event counters (cycle/stall/flush/retire) with a snapshot bank and a one-cycle read port.
// Counting runs only in RUN and freezes in DONE once the cycle budget is spent.
module pipe_event_counter #(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stall_i,
  input  logic                 branch_i,
  input  logic                 flush_i,
  input  logic                 retire_i,
  input  logic                 clr_i,
  input  logic                 snap_i,
  pipe_event_counter_if.slave  rd,
  output logic                 run_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter bank index: 0=cycle 1=stall 2=flush 3=retire.
  localparam int N_CNT = 4;
  localparam logic [63:0] LIMIT_64 = 64'(CYCLE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q  [N_CNT];
  logic [CNT_W-1:0] cnt_d  [N_CNT];
  logic [CNT_W-1:0] snap_q [N_CNT];
  logic [CNT_W-1:0] snap_d [N_CNT];
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_ack_q, rd_ack_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    rd_ack_d  = rd.rd_req_i;
    rd_data_d = rd_data_q;

    // Reads see the registered (pre-increment) values of this edge.
    if (rd.rd_req_i) begin
      rd_data_d = rd.rd_sel_i[2] ? snap_q[rd.rd_sel_i[1:0]] : cnt_q[rd.rd_sel_i[1:0]];
    end

    if (clr_i) begin
      for (int i = 0; i < N_CNT; i++) begin
        cnt_d[i]  = '0;
        snap_d[i] = '0;
      end
      state_d = start_i ? ST_RUN : ST_IDLE;
    end else begin
      if (snap_i) begin
        snap_d = cnt_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) state_d = ST_RUN;
        end
        ST_RUN: begin
          cnt_d[0] = sat_inc(cnt_q[0]);
          if (stall_i && !branch_i) cnt_d[1] = sat_inc(cnt_q[1]);
          if (flush_i)              cnt_d[2] = sat_inc(cnt_q[2]);
          if (retire_i)             cnt_d[3] = sat_inc(cnt_q[3]);
          // The budget is met on the edge where the cycle count reaches the limit.
          if ((CYCLE_LIMIT != 0) && (64'(cnt_d[0]) == LIMIT_64)) begin
            state_d = ST_DONE;
          end else if (!start_i) begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i]  <= cnt_d[i];
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign rd.rd_data_o = rd_data_q;
  assign rd.rd_ack_o  = rd_ack_q;
  assign run_o        = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);

endmodule
